// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module      : alu_share_arbiter_if
// Description : Requester handshake, response and ALU-side bus of the shared
//               ALU arbiter. The slave modport is the arbiter's view.
// Revision    : 1.0 - initial release
//==============================================================================
interface alu_share_arbiter_if;
    logic        req0;
    logic        req1;
    logic [3:0]  ctrl0;
    logic [3:0]  ctrl1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] b0;
    logic [31:0] b1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [31:0] rsp_result;
    logic [7:0]  rsp_status;
    logic        busy;
    logic [3:0]  alu_control;
    logic [31:0] alu_op_1;
    logic [31:0] alu_op_2;
    logic [31:0] alu_result;
    logic [7:0]  alu_status;

    modport slave (
        input  req0, req1, ctrl0, ctrl1, a0, a1, b0, b1,
        output gnt0, gnt1, done0, done1, rsp_result, rsp_status, busy,
        output alu_control, alu_op_1, alu_op_2,
        input  alu_result, alu_status
    );

    modport master (
        output req0, req1, ctrl0, ctrl1, a0, a1, b0, b1,
        input  gnt0, gnt1, done0, done1, rsp_result, rsp_status, busy,
        input  alu_control, alu_op_1, alu_op_2,
        output alu_result, alu_status
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin arbiter/sequencer time-sharing one 32-bit ALU
//               between two requesters; holds operands for EXEC_CYCLES cycles.
// Revision    : 1.0 - initial release
//==============================================================================
module alu_share_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    alu_share_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    localparam logic [3:0] c_count_load = 4'(EXEC_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_count;
    logic [3:0]  w_count_nxt;
    logic        r_last_grant;
    logic        w_last_grant_nxt;
    logic        r_owner;
    logic        w_owner_nxt;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_capture;
    logic        r_done0;
    logic        r_done1;
    logic [31:0] r_rsp_result;
    logic [7:0]  r_rsp_status;
    logic [3:0]  r_alu_control;
    logic [31:0] r_alu_op_1;
    logic [31:0] r_alu_op_2;

    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_last_grant_nxt = r_last_grant;
        w_owner_nxt      = r_owner;
        w_gnt0           = 1'b0;
        w_gnt1           = 1'b0;
        w_capture        = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Grants are masked while reset is held so every output reads 0.
                if (!reset) begin
                    if (bus.req0 && (!bus.req1 || r_last_grant)) begin
                        w_gnt0 = 1'b1;
                    end else if (bus.req1) begin
                        w_gnt1 = 1'b1;
                    end
                end
                if (w_gnt0 || w_gnt1) begin
                    w_owner_nxt      = w_gnt1;
                    w_last_grant_nxt = w_gnt1;
                    w_count_nxt      = c_count_load;
                    w_state_nxt      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_count == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_count_nxt = r_count - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_count      <= 4'd0;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_owner      <= w_owner_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_rsp_result <= 32'd0;
            r_rsp_status <= 8'd0;
        end else begin
            r_done0 <= w_capture && !r_owner;
            r_done1 <= w_capture && r_owner;
            if (w_capture) begin
                r_rsp_result <= bus.alu_result;
                r_rsp_status <= bus.alu_status;
            end
        end
    end

    // Operand registers only move on a grant, so the ALU sees stable inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_control <= 4'd0;
            r_alu_op_1    <= 32'd0;
            r_alu_op_2    <= 32'd0;
        end else if (w_gnt0) begin
            r_alu_control <= bus.ctrl0;
            r_alu_op_1    <= bus.a0;
            r_alu_op_2    <= bus.b0;
        end else if (w_gnt1) begin
            r_alu_control <= bus.ctrl1;
            r_alu_op_1    <= bus.a1;
            r_alu_op_2    <= bus.b1;
        end
    end

    assign bus.gnt0        = w_gnt0;
    assign bus.gnt1        = w_gnt1;
    assign bus.done0       = r_done0;
    assign bus.done1       = r_done1;
    assign bus.rsp_result  = r_rsp_result;
    assign bus.rsp_status  = r_rsp_status;
    assign bus.busy        = (r_state == S_EXEC);
    assign bus.alu_control = r_alu_control;
    assign bus.alu_op_1    = r_alu_op_1;
    assign bus.alu_op_2    = r_alu_op_2;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_alu_share_arbiter
// Description : Bench for alu_share_arbiter with EXEC_CYCLES=1 and 3 instances
//               side by side against a transaction-timeline reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_alu_share_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_share_arbiter_if if0 ();
    alu_share_arbiter_if if1 ();

    alu_share_arbiter #(.EXEC_CYCLES(1)) dut_ec1 (.clk(clk), .reset(rst), .bus(if0));
    alu_share_arbiter #(.EXEC_CYCLES(3)) dut_ec3 (.clk(clk), .reset(rst), .bus(if1));

    // Environment ALU: status = {zero, negative, carry, overflow, ctrl}
    function automatic logic [39:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        cy;
        logic        ov;
        s = '0; cy = 1'b0; ov = 1'b0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cy = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0110: begin
                s = {1'b0, a} - {1'b0, b}; r = s[31:0]; cy = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0111: r = {31'd0, $signed(a) < $signed(b)};
            4'b1100: r = ~(a | b);
            default: r = a ^ b;
        endcase
        return {r == 32'd0, r[31], cy, ov, c, r};
    endfunction

    logic [39:0] alu_w0, alu_w1;
    assign alu_w0 = alu_fn(if0.alu_control, if0.alu_op_1, if0.alu_op_2);
    assign alu_w1 = alu_fn(if1.alu_control, if1.alu_op_1, if1.alu_op_2);
    assign if0.alu_result = alu_w0[31:0];
    assign if0.alu_status = alu_w0[39:32];
    assign if1.alu_result = alu_w1[31:0];
    assign if1.alu_status = alu_w1[39:32];

    // Requester side, per DUT index (0: EXEC_CYCLES=1, 1: EXEC_CYCLES=3)
    logic        pend0 [2];
    logic        pend1 [2];
    logic [3:0]  ctl0  [2];
    logic [3:0]  ctl1  [2];
    logic [31:0] a0v   [2];
    logic [31:0] b0v   [2];
    logic [31:0] a1v   [2];
    logic [31:0] b1v   [2];

    assign if0.req0 = pend0[0]; assign if0.req1 = pend1[0];
    assign if0.ctrl0 = ctl0[0]; assign if0.ctrl1 = ctl1[0];
    assign if0.a0 = a0v[0]; assign if0.b0 = b0v[0];
    assign if0.a1 = a1v[0]; assign if0.b1 = b1v[0];
    assign if1.req0 = pend0[1]; assign if1.req1 = pend1[1];
    assign if1.ctrl0 = ctl0[1]; assign if1.ctrl1 = ctl1[1];
    assign if1.a0 = a0v[1]; assign if1.b0 = b0v[1];
    assign if1.a1 = a1v[1]; assign if1.b1 = b1v[1];

    logic        g0 [2], g1 [2], d0 [2], d1 [2], bz [2];
    logic [31:0] rr [2], o1 [2], o2 [2];
    logic [7:0]  rs [2];
    logic [3:0]  ac [2];

    assign g0[0] = if0.gnt0;  assign g0[1] = if1.gnt0;
    assign g1[0] = if0.gnt1;  assign g1[1] = if1.gnt1;
    assign d0[0] = if0.done0; assign d0[1] = if1.done0;
    assign d1[0] = if0.done1; assign d1[1] = if1.done1;
    assign bz[0] = if0.busy;  assign bz[1] = if1.busy;
    assign rr[0] = if0.rsp_result; assign rr[1] = if1.rsp_result;
    assign rs[0] = if0.rsp_status; assign rs[1] = if1.rsp_status;
    assign ac[0] = if0.alu_control; assign ac[1] = if1.alu_control;
    assign o1[0] = if0.alu_op_1; assign o1[1] = if1.alu_op_1;
    assign o2[0] = if0.alu_op_2; assign o2[1] = if1.alu_op_2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic auto_req = 1'b0;
    logic gseen0 [2], gseen1 [2];
    logic [31:0] res0 [2], res1 [2];
    logic [7:0]  st0 [2], st1 [2];
    int gorder [$];

    // Reference model: timeline of when each DUT is free and when a result lands
    int          m_free [2], m_last [2], m_done_cyc [2], m_done_port [2];
    logic [31:0] m_done_res [2], m_rsp_res [2], m_op1 [2], m_op2 [2];
    logic [7:0]  m_done_st [2], m_rsp_st [2];
    logic [3:0]  m_ctrl [2];

    function automatic int ec(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        m_free[d] = 0; m_last[d] = 1; m_done_cyc[d] = -1; m_done_port[d] = 0;
        m_rsp_res[d] = '0; m_rsp_st[d] = '0; m_done_res[d] = '0; m_done_st[d] = '0;
        m_ctrl[d] = '0; m_op1[d] = '0; m_op2[d] = '0;
    endtask

    task automatic check_dut(input int d);
        logic idle, eg0, eg1, ed0, ed1;
        logic [39:0] f;
        string pfx;
        pfx = $sformatf("dut%0d cyc%0d", d, cyc);
        gseen0[d] = g0[d];
        gseen1[d] = g1[d];
        if (rst) begin
            chk({pfx, " rst gnt0"}, 32'(g0[d]), 0);
            chk({pfx, " rst gnt1"}, 32'(g1[d]), 0);
            chk({pfx, " rst done0"}, 32'(d0[d]), 0);
            chk({pfx, " rst done1"}, 32'(d1[d]), 0);
            chk({pfx, " rst busy"}, 32'(bz[d]), 0);
            chk({pfx, " rst rsp_result"}, rr[d], 0);
            chk({pfx, " rst rsp_status"}, 32'(rs[d]), 0);
            chk({pfx, " rst alu_control"}, 32'(ac[d]), 0);
            chk({pfx, " rst alu_op_1"}, o1[d], 0);
            chk({pfx, " rst alu_op_2"}, o2[d], 0);
            model_reset(d);
            return;
        end
        idle = (cyc >= m_free[d]);
        eg0  = idle && pend0[d] && (!pend1[d] || m_last[d] == 1);
        eg1  = idle && pend1[d] && !eg0;
        ed0  = (cyc == m_done_cyc[d]) && (m_done_port[d] == 0);
        ed1  = (cyc == m_done_cyc[d]) && (m_done_port[d] == 1);
        if (cyc == m_done_cyc[d]) begin
            m_rsp_res[d] = m_done_res[d];
            m_rsp_st[d]  = m_done_st[d];
        end
        chk({pfx, " gnt0"}, 32'(g0[d]), 32'(eg0));
        chk({pfx, " gnt1"}, 32'(g1[d]), 32'(eg1));
        chk({pfx, " done0"}, 32'(d0[d]), 32'(ed0));
        chk({pfx, " done1"}, 32'(d1[d]), 32'(ed1));
        chk({pfx, " busy"}, 32'(bz[d]), 32'(!idle));
        chk({pfx, " rsp_result"}, rr[d], m_rsp_res[d]);
        chk({pfx, " rsp_status"}, 32'(rs[d]), 32'(m_rsp_st[d]));
        chk({pfx, " alu_control"}, 32'(ac[d]), 32'(m_ctrl[d]));
        chk({pfx, " alu_op_1"}, o1[d], m_op1[d]);
        chk({pfx, " alu_op_2"}, o2[d], m_op2[d]);
        if (d0[d]) begin res0[d] = rr[d]; st0[d] = rs[d]; end
        if (d1[d]) begin res1[d] = rr[d]; st1[d] = rs[d]; end
        if (d == 0 && (g0[d] || g1[d])) gorder.push_back(int'(g1[d]));
        if (eg0 || eg1) begin
            m_last[d]      = eg1 ? 1 : 0;
            m_free[d]      = cyc + ec(d) + 1;
            m_done_cyc[d]  = cyc + ec(d) + 1;
            m_done_port[d] = eg1 ? 1 : 0;
            m_ctrl[d] = eg1 ? ctl1[d] : ctl0[d];
            m_op1[d]  = eg1 ? a1v[d] : a0v[d];
            m_op2[d]  = eg1 ? b1v[d] : b0v[d];
            f = alu_fn(m_ctrl[d], m_op1[d], m_op2[d]);
            m_done_res[d] = f[31:0];
            m_done_st[d]  = f[39:32];
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (gseen0[d] && !auto_req) pend0[d] = 1'b0;
            if (gseen1[d] && !auto_req) pend1[d] = 1'b0;
        end
    endtask

    task automatic issue(input int d, input int p, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            pend0[d] = 1'b1; ctl0[d] = c; a0v[d] = a; b0v[d] = b;
        end else begin
            pend1[d] = 1'b1; ctl1[d] = c; a1v[d] = a; b1v[d] = b;
        end
    endtask

    task automatic issue_both(input int p, input logic [3:0] c,
                              input logic [31:0] a, input logic [31:0] b);
        issue(0, p, c, a, b);
        issue(1, p, c, a, b);
    endtask

    function automatic logic [3:0] pick_ctrl();
        case ($urandom_range(0, 6))
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0010;
            3: return 4'b0110;
            4: return 4'b0111;
            5: return 4'b1100;
            default: return 4'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            pend0[d] = 1'b0; pend1[d] = 1'b0;
            ctl0[d] = '0; ctl1[d] = '0;
            a0v[d] = '0; b0v[d] = '0; a1v[d] = '0; b1v[d] = '0;
            res0[d] = '0; res1[d] = '0; st0[d] = '0; st1[d] = '0;
            gseen0[d] = 1'b0; gseen1[d] = 1'b0;
            model_reset(d);
        end
        repeat (2) step();
        rst = 1'b0;
        step();

        // Add on port 0
        issue_both(0, 4'b0010, 32'd5, 32'd7);
        repeat (6) step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d add_result", d), res0[d], 32'd12);
            chk($sformatf("dut%0d add_zero_flag", d), 32'(st0[d][7]), 0);
        end

        // Subtract to zero on port 1
        issue_both(1, 4'b0110, 32'd3, 32'd3);
        repeat (6) step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d sub_result", d), res1[d], 32'd0);
            chk($sformatf("dut%0d sub_zero_flag", d), 32'(st1[d][7]), 1);
        end

        // Continuous contention straight out of reset
        rst = 1'b1;
        issue_both(0, 4'b0010, 32'd1, 32'd2);
        issue_both(1, 4'b0010, 32'd10, 32'd20);
        auto_req = 1'b1;
        step();
        rst = 1'b0;
        gorder.delete();
        repeat (8) step();
        auto_req = 1'b0;
        repeat (10) step();
        chk("contention grant count", 32'(gorder.size() >= 4), 1);
        if (gorder.size() >= 4) begin
            chk("contention order[0]", 32'(gorder[0]), 0);
            chk("contention order[1]", 32'(gorder[1]), 1);
            chk("contention order[2]", 32'(gorder[2]), 0);
            chk("contention order[3]", 32'(gorder[3]), 1);
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d contention result0", d), res0[d], 32'd3);
            chk($sformatf("dut%0d contention result1", d), res1[d], 32'd30);
        end

        // Stretched execute with a late port-1 request
        issue_both(0, 4'b0001, 32'h1234_0000, 32'h0000_5678);
        step();
        issue_both(1, 4'b0110, 32'd50, 32'd8);
        repeat (10) step();
        chk("dut1 stretched result0", res0[1], 32'h1234_5678);
        chk("dut1 stretched result1", res1[1], 32'd42);

        // Reset in the second execute cycle
        issue_both(0, 4'b0010, 32'd100, 32'd23);
        step();
        step();
        rst = 1'b1;
        issue_both(0, 4'b0010, 32'd7, 32'd8);
        issue_both(1, 4'b0010, 32'd9, 32'd9);
        step();
        rst = 1'b0;
        step();
        chk("dut1 restart gnt0", 32'(gseen0[1]), 1);
        chk("dut1 restart gnt1", 32'(gseen1[1]), 0);
        repeat (10) step();

        // Request dropped right after its grant
        issue_both(0, 4'b0111, 32'hFFFF_FFFB, 32'd3);
        repeat (6) step();
        chk("dut0 drop result", res0[0], 32'd1);
        chk("dut1 drop result", res0[1], 32'd1);

        // Random traffic
        repeat (400) begin
            for (int d = 0; d < 2; d++) begin
                if (!pend0[d] && $urandom_range(0, 3) == 0)
                    issue(d, 0, pick_ctrl(), pick_op(), pick_op());
                if (!pend1[d] && $urandom_range(0, 3) == 0)
                    issue(d, 1, pick_ctrl(), pick_op(), pick_op());
            end
            step();
        end
        repeat (12) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
